mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares the team's 2-bit, 4:1 structural mux among four requesters. Each requester raises `req[i]` to claim the mux. The block registers a one-hot grant, drives the mux select, and presents the winner's 2-bit data with a valid flag. Tenure is bounded by `MAX_HOLD` cycles so no requester can starve the others.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per tenure; legal range 1–255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  arbitration enable; when low, no new tenure starts.
- `req`  in  4  request per requester; bit i = requester i.
- `d0`, `d1`, `d2`, `d3`  in  2 each  requester data, routed to the mux inputs i0..i3.
- `grant`  out  4  registered one-hot grant; all zero when idle.
- `sel`  out  2  registered mux select, equal to the index of the granted requester.
- `out_data`  out  2  mux output, forced to 2'b00 when `out_valid` is low.
- `out_valid`  out  1  high while in GRANT and `req[sel]` is high.
- `busy`  out  1  high while in GRANT.

## Operation
- Reset values, applied asynchronously: state IDLE, `grant`=0, `sel`=0, round-robin pointer `ptr`=0, hold counter `hcnt`=0, `out_valid`=0, `out_data`=0, `busy`=0.
- Pick function: starting at `ptr`, search `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4) and take the first i with `req[i]` high.
- IDLE:
  - If `en` is high and `req` is nonzero, go to GRANT with winner k.
  - Set `grant` = 1<<k, `sel` = k, `ptr` = k+1 mod 4, `hcnt` = 0.
- GRANT, owner k: `hcnt` increments each cycle, saturating at `MAX_HOLD`-1. The tenure ends at the first edge where either condition holds:
  - (a) `req[k]` is low;
  - (b) `hcnt` == `MAX_HOLD`-1.
- End of tenure, same edge:
  - If `en` is high and any request remains, immediately grant the pick winner using the already-advanced `ptr`. There is no idle gap.
  - Otherwise go to IDLE.
  - On hold expiry with k as the only requester, k is regranted for a fresh tenure with `hcnt`=0.
- `en` falling during GRANT: the current tenure completes normally, then the block goes to IDLE.
- `out_data` = mux(d0..d3, `sel`) AND-gated by `out_valid`. This path is purely combinational from `d*`.
- `hcnt` width is ceil(log2(`MAX_HOLD`)), minimum 1 bit. With `MAX_HOLD`=1, every tenure lasts exactly one cycle.

## Timing
- Request to grant: `req` sampled at edge n; `grant`, `sel` and `busy` are valid after edge n.
- Grant to data: `out_data` follows `d[sel]` in the same cycle (zero latency).
- Release: when a requester drops `req` in cycle c, its `grant` is still high during c but `out_valid` is already low. The new grant is visible after the closing edge of c.
- Maximum tenure: `MAX_HOLD` cycles.
- Worst-case wait for a continuously requesting input: 3·`MAX_HOLD` cycles.
- Simultaneous requests: resolved purely by the rotating `ptr`; there is no fixed priority.
- `req` changes for non-owners during GRANT have no effect until the tenure ends.
- Reset asserted mid-tenure: all outputs clear immediately, without waiting for the clock. The first post-reset arbitration starts at `ptr`=0.

## Structure
- Shared package `mux4_arb_pkg`:
  - state encoding: IDLE=1'b0, GRANT=1'b1;
  - constant `N_REQ`=4;
  - constant `SEL_W`=2.
- One sub-module: the existing 2-bit structural 4:1 mux, instantiated with `d0..d3` and `sel`. Its output is gated by `out_valid` in this block.
- All sequential logic sits in one always block sensitive to `posedge clk or posedge rst`. The pick function is a combinational function.

## Test plan
- Reset then single request: `rst` pulse, `d2`=2'b10, `req`=4'b0100 held → after one edge, `grant`=0100, `sel`=2, `out_data`=10, `out_valid`=1. After `MAX_HOLD`(4) cycles, requester 2 is regranted with `hcnt` reset.
- All four requesting with `MAX_HOLD`=4 → grant order 0,1,2,3,0, each tenure exactly 4 cycles, no idle cycle between tenures.
- Early release: `req`=0011, requester 0 drops `req` after 2 cycles → `out_valid`=0 in the drop cycle, then `grant`=0010 on the next edge.
- `en` low mid-tenure with `req`=1111 → owner finishes its tenure, then IDLE with `grant`=0000. `en` high again → next grant goes to the owner index +1.
- Async reset mid-GRANT (`grant`=1000) → `grant`, `sel`, `out_data`, `out_valid` and `busy` all go to 0 before the next clock edge. With `req`=1001 held after reset release, the first grant goes to requester 0.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the round-robin arbiter around the 2-bit 4:1 mux.
package mux4_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;
endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// Structural 2-bit 4:1 mux built from two levels of 2:1 selection.
module mux4_rr_arbiter_mux (
    input  logic [1:0] i0,
    input  logic [1:0] i1,
    input  logic [1:0] i2,
    input  logic [1:0] i3,
    input  logic [1:0] s,
    output logic [1:0] y
);
    logic [1:0] lo, hi;

    assign lo = s[0] ? i1 : i0;
    assign hi = s[0] ? i3 : i2;
    assign y  = s[1] ? hi : lo;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing the 4:1 mux among four requesters, with
// tenure bounded to MAX_HOLD cycles.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       d0,
    input  logic [1:0]       d1,
    input  logic [1:0]       d2,
    input  logic [1:0]       d3,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic [1:0]       out_data,
    output logic             out_valid,
    output logic             busy
);
    localparam int            HW   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [SEL_W:0]   pk;
    logic [SEL_W-1:0] win;
    logic             start;
    logic [1:0]       mux_y;

    // Returns {found, index}; scanning offsets high-to-low lets the
    // smallest offset from p overwrite the others.
    function automatic logic [SEL_W:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [SEL_W-1:0] p);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            idx = p + SEL_W'(j);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pk  = pick(req, ptr_q);
    assign win = pk[SEL_W-1:0];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        start   = 1'b0;
        case (state_q)
            IDLE: start = en && pk[SEL_W];
            GRANT: begin
                if (!req[sel_q] || hcnt_q == HMAX) begin
                    // ptr already points past the owner, so a lone
                    // expiring owner is only regranted when no one else asks.
                    start = en && pk[SEL_W];
                    if (!start) begin
                        state_d = IDLE;
                        grant_d = '0;
                        sel_d   = '0;
                        hcnt_d  = '0;
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = GRANT;
            grant_d = N_REQ'(1) << win;
            sel_d   = win;
            ptr_d   = win + SEL_W'(1);
            hcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    mux4_rr_arbiter_mux u_mux (
        .i0 (d0),
        .i1 (d1),
        .i2 (d2),
        .i3 (d3),
        .s  (sel_q),
        .y  (mux_y)
    );

    assign busy      = (state_q == GRANT);
    assign out_valid = busy && req[sel_q];
    assign out_data  = mux_y & {2{out_valid}};
    assign grant     = grant_q;
    assign sel       = sel_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scenario bench for mux4_rr_arbiter: expected output vectors are queued as
// stimulus is applied and compared against the DUT after each edge.
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] dv [4];
    logic [3:0] grant, grant1;
    logic [1:0] sel, sel1, out_data, out_data1;
    logic       out_valid, out_valid1, busy, busy1;
    logic [9:0] obs, obs1;
    logic [9:0] sb [$];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
        .grant(grant), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .busy(busy)
    );

    mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
        .grant(grant1), .sel(sel1), .out_data(out_data1),
        .out_valid(out_valid1), .busy(busy1)
    );

    assign obs  = {grant, sel, busy, out_valid, out_data};
    assign obs1 = {grant1, sel1, busy1, out_valid1, out_data1};

    // {grant, sel, busy, valid, data}; busy follows any grant bit.
    function automatic logic [9:0] ex(input logic [3:0] g, input logic [1:0] s,
                                      input logic v, input logic [1:0] d);
        return {g, s, |g, v, v ? d : 2'b00};
    endfunction

    function automatic logic [9:0] own(input int k);
        return ex(4'b0001 << k, 2'(k), 1'b1, dv[k]);
    endfunction

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        en  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        rst = 1'b1;
        #1;
        sb.push_back(10'd0);
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_main got=%b want=%b", obs, e); end
        total++;
        if (obs1 !== e) begin bad++; $display("FAIL reset_hold1 got=%b want=%b", obs1, e); end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        sb.push_back(10'd0);
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_idle got=%b want=%b", obs, e); end
    endtask

    task automatic test_single();
        logic [9:0] e;
        rst_pulse();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req = (i < 5) ? 4'b0100 : (i < 9) ? 4'b1100 : 4'b0000;
            if (i < 8)      sb.push_back(own(2));
            else if (i == 8) sb.push_back(own(3));
            else            sb.push_back(10'd0);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL single cyc=%0d got=%b want=%b", i, obs, e); end
        end
    endtask

    task automatic test_all_four();
        logic [9:0] e;
        rst_pulse();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req = 4'b1111;
            sb.push_back(own((i / 4) % 4));
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL all_four cyc=%0d got=%b want=%b", i, obs, e); end
        end
    endtask

    task automatic test_release();
        logic [9:0] e;
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req = (i < 2) ? 4'b0011 : (i < 4) ? 4'b0010 : 4'b0000;
            if (i == 2) begin
                sb.push_back(ex(4'b0001, 2'd0, 1'b0, 2'b00));
                #1;
                e = sb.pop_front();
                total++;
                if (obs !== e) begin bad++; $display("FAIL release_drop got=%b want=%b", obs, e); end
            end
            if (i < 2)      sb.push_back(own(0));
            else if (i < 4) sb.push_back(own(1));
            else            sb.push_back(10'd0);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL release cyc=%0d got=%b want=%b", i, obs, e); end
        end
    endtask

    task automatic test_en_low();
        logic [9:0] e;
        rst_pulse();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = 4'b1111;
            en  = (i == 0) || (i >= 6);
            if (i < 4)      sb.push_back(own(0));
            else if (i < 6) sb.push_back(10'd0);
            else            sb.push_back(own(1));
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL en_low cyc=%0d got=%b want=%b", i, obs, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] e;
        logic [3:0] first [2];
        first[0] = 4'b1000;
        first[1] = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            rst_pulse();
            @(negedge clk);
            req = first[c];
            sb.push_back(own(c == 0 ? 3 : 1));
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL async_pre c=%0d got=%b want=%b", c, obs, e); end
            @(negedge clk);
            rst = 1'b1;
            sb.push_back(10'd0);
            #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL async_clear c=%0d got=%b want=%b", c, obs, e); end
            req = 4'b1001;
            @(negedge clk);
            rst = 1'b0;
            sb.push_back(own(0));
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL async_post c=%0d got=%b want=%b", c, obs, e); end
        end
    endtask

    task automatic test_hold1();
        logic [9:0] e;
        rst_pulse();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req = 4'b0011;
            sb.push_back(own(i % 2));
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs1 !== e) begin bad++; $display("FAIL hold1 cyc=%0d got=%b want=%b", i, obs1, e); end
        end
    endtask

    initial begin
        dv[0] = 2'b11;
        dv[1] = 2'b01;
        dv[2] = 2'b10;
        dv[3] = 2'b01;
        test_reset();
        test_single();
        test_all_four();
        test_release();
        test_en_low();
        test_async_reset();
        test_hold1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
